multicycle_control_fsm: RTL and testbench

- Multicycle RISC-V (RV32I subset) control unit; the producer side of the datapath's 3-bit ALUControl interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives all datapath select and enable lines plus the ALU operation code.
- Sits between the instruction register (op/funct fields) and the datapath. Consumes the ALU zero flag for branch resolution.

---
 rtl/multicycle_control_fsm_if.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the instruction register/datapath and the multicycle control unit.
// The master modport belongs to the control unit, which drives every select/enable line.
interface multicycle_control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset control unit: Moore state machine plus ALU/immediate decode.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_fsm_if.master    bus
);
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch, mem_write, ir_write, reg_write;
    logic       adr_src;
    logic [1:0] result_src, src_a, src_b;
    logic       ill_dec, ill_alu;
    logic [2:0] alu_ctl;
    logic [1:0] imm_src;

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; anything not set by a state stays 0.
    always_comb begin
        state_d    = S_FETCH;
        alu_op     = 2'b00;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        ill_dec    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d = S_FETCH;
                        ill_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a = 2'b10;
                src_b = 2'b01;
                if (bus.op == OP_LW)      state_d = S_MEMREAD;
                else if (bus.op == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                src_a  = 2'b10;
                alu_op = 2'b01;
                branch = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU operation decode; unsupported funct3 flags illegal but still completes as add.
    always_comb begin
        alu_ctl = 3'b000;
        ill_alu = 1'b0;
        case (alu_op)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_ctl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: ill_alu = 1'b1;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    // Immediate format select from opcode.
    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Reset masks every side-effecting enable, even mid-instruction.
    assign bus.PCWrite       = ~reset & (pc_update | (branch & bus.zero));
    assign bus.MemWrite      = ~reset & mem_write;
    assign bus.IRWrite       = ~reset & ir_write;
    assign bus.RegWrite      = ~reset & reg_write;
    assign bus.illegal_instr = ~reset & (ill_dec | ill_alu);
    assign bus.AdrSrc        = adr_src;
    assign bus.ResultSrc     = result_src;
    assign bus.ALUSrcA       = src_a;
    assign bus.ALUSrcB       = src_b;
    assign bus.ImmSrc        = imm_src;
    assign bus.ALUControl    = alu_ctl;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control unit; each cycle's full output set is checked.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite,illegal}
    function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        logic [16:0] got;
        got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
               bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.RegWrite, bus.illegal_instr};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
        end
    endtask

    // Advance one state, landing mid-cycle on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
        #1;
    endtask

    // R/I ALU instruction: FETCH, DECODE, EXEC, ALUWB, then back in FETCH.
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] exp_alu, input logic exp_ill);
        set_instr(op, f3, f7, 1'b0);
        chk({tag, "_fetch"}, mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk({tag, "_decode"}, mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk({tag, "_exec"}, mk(0, 0, 0, 0, 2'b00, 2'b10, op[4] ? (op[5] ? 2'b00 : 2'b01) : 2'b00,
                               2'b00, exp_alu, 0, exp_ill));
        tick(); #1;
        chk({tag, "_aluwb"}, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        tick();
    endtask

    localparam logic [16:0] FETCH_LW = 17'b1_0_0_1_10_00_10_00_000_0_0;

    initial begin
        reset = 1'b1;
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        #1;
        // Held in reset in FETCH: all enables masked, selects still FETCH's
        chk("reset_hold", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        reset = 1'b0;
        #1;
        chk("lw_fetch", FETCH_LW);
        tick(); #1;
        chk("lw_decode", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk("lw_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk("lw_memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk("lw_memwb", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        tick();

        // ALU instructions (each starts in FETCH, which also checks prior CPI)
        run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001, 1'b0);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 1'b0);
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101, 1'b0);
        run_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b011, 1'b0);
        run_alu("and",  7'b0110011, 3'b111, 1'b0, 3'b010, 1'b0);
        run_alu("add",  7'b0110011, 3'b000, 1'b0, 3'b000, 1'b0);
        run_alu("badf3", 7'b0110011, 3'b001, 1'b0, 3'b000, 1'b1);

        // beq taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        chk("beq1_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0));
        tick(); #1;
        chk("beq1_decode", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0));
        tick(); #1;
        chk("beq1_branch", mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0));
        tick();
        // beq not taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        chk("beq0_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0));
        tick(); tick(); #1;
        chk("beq0_branch", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0));
        tick();

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        chk("jal_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0));
        tick(); tick(); #1;
        chk("jal_jal", mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));
        tick(); #1;
        chk("jal_aluwb", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0));
        tick();

        // Illegal opcode: flagged in DECODE, then straight back to FETCH
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        chk("ill_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
        tick(); #1;
        chk("ill_decode", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 1));
        tick();

        // sw full sequence
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        chk("sw_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
        tick(); tick(); #1;
        chk("sw_memadr", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0));
        tick(); #1;
        chk("sw_memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        tick();

        // sw interrupted by reset in MEMWRITE
        #1;
        chk("sw2_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("sw2_rst_memwrite", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        tick();
        reset = 1'b0;
        #1;
        chk("after_rst_fetch", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
